// File: rtl/alu_pkg.sv
// Shared ALU control codes and the multiplier sequencer state type.
package alu_pkg;

  localparam logic [3:0] AND_OP = 4'd0;
  localparam logic [3:0] OR_OP  = 4'd1;
  localparam logic [3:0] ADD_OP = 4'd2;
  localparam logic [3:0] SLL_OP = 4'd3;
  localparam logic [3:0] SRL_OP = 4'd4;
  localparam logic [3:0] SUB_OP = 4'd6;
  localparam logic [3:0] SLT_OP = 4'd7;
  localparam logic [3:0] MUL_OP = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: accumulator, shifting multiplicand and
// multiplier, and the step counter. Sequenced by load/step strobes.
module mul_shift_add_dp
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_operand_a,
  input  logic [DATA_W-1:0] i_operand_b,
  output logic [DATA_W-1:0] o_acc_next,
  output logic              o_mplier_zero_next,
  output logic              o_cnt_last
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_acc_next;

  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) w_acc_next = r_acc + r_mcand;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= i_operand_a;
      r_mplier <= i_operand_b;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // Look-ahead flags describe the state after the step taken this cycle.
  assign o_acc_next         = w_acc_next;
  assign o_mplier_zero_next = ((r_mplier >> 1) == '0);
  assign o_cnt_last         = (r_cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/mul_sequencer.sv
// Iterative MUL unit beside the EX-stage ALU: stalls the pipeline while a
// shift-add multiply runs, then presents the low DATA_W product bits.
module mul_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              op_valid_i,
  input  logic [3:0]        alu_control_i,
  input  logic [DATA_W-1:0] operand_a_i,
  input  logic [DATA_W-1:0] operand_b_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] result_o,
  output logic              result_valid_o
);

  mul_state_t        r_state;
  logic [DATA_W-1:0] r_result;
  logic              r_result_valid;

  logic              w_start;
  logic              w_load;
  logic              w_step;
  logic              w_finish;
  logic [DATA_W-1:0] w_acc_next;
  logic              w_mplier_zero_next;
  logic              w_cnt_last;

  assign w_start  = op_valid_i & (alu_control_i == MUL_OP) & ~flush_i;
  assign w_load   = (r_state == IDLE) & w_start;
  assign w_step   = (r_state == RUN) & ~flush_i;
  assign w_finish = w_cnt_last | ((EARLY_EXIT != 0) & w_mplier_zero_next);

  mul_shift_add_dp #(
    .DATA_W(DATA_W)
  ) u_dp (
    .clk               (clk),
    .arst              (arst),
    .i_load            (w_load),
    .i_step            (w_step),
    .i_operand_a       (operand_a_i),
    .i_operand_b       (operand_b_i),
    .o_acc_next        (w_acc_next),
    .o_mplier_zero_next(w_mplier_zero_next),
    .o_cnt_last        (w_cnt_last)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state        <= IDLE;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_result_valid <= 1'b0;
          if (w_start) r_state <= RUN;
        end
        RUN: begin
          if (flush_i) begin
            r_state <= IDLE;
          end else if (w_finish) begin
            r_state        <= DONE;
            r_result       <= w_acc_next;
            r_result_valid <= 1'b1;
          end
        end
        DONE: begin
          r_result_valid <= 1'b0;
          r_state        <= IDLE;
        end
        default: begin
          r_result_valid <= 1'b0;
          r_state        <= IDLE;
        end
      endcase
    end
  end

  // A flush landing on the DONE cycle squashes the already-registered valid.
  assign result_valid_o = r_result_valid & ~flush_i;
  assign result_o       = r_result;
  assign busy_o         = (r_state != IDLE);
  assign stall_o        = ~arst & (w_load | w_step);

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench: two instances (EARLY_EXIT=1 and 0) share stimulus and
// are compared against a plain-arithmetic product/latency model.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        arst;
  logic        op_valid_i;
  logic [3:0]  alu_control_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        flush_i;

  logic        stall_e1, busy_e1, valid_e1;
  logic [31:0] result_e1;
  logic        stall_e0, busy_e0, valid_e0;
  logic [31:0] result_e0;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  always #5 clk = ~clk;

  mul_sequencer #(.DATA_W(32), .EARLY_EXIT(1)) u_e1 (
    .clk(clk), .arst(arst), .op_valid_i(op_valid_i), .alu_control_i(alu_control_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .flush_i(flush_i),
    .stall_o(stall_e1), .busy_o(busy_e1), .result_o(result_e1), .result_valid_o(valid_e1)
  );

  mul_sequencer #(.DATA_W(32), .EARLY_EXIT(0)) u_e0 (
    .clk(clk), .arst(arst), .op_valid_i(op_valid_i), .alu_control_i(alu_control_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .flush_i(flush_i),
    .stall_o(stall_e0), .busy_o(busy_e0), .result_o(result_e0), .result_valid_o(valid_e0)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    int unsigned lat1;
    int unsigned lat0;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycles from accept to DONE with early exit: 1 + max(1, msb index + 1).
  function automatic int unsigned model_lat1(input logic [31:0] b);
    int unsigned k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    if (k == 0) k = 1;
    return 1 + k;
  endfunction

  // Per-run observations, indexed by cycle offset from accept.
  logic [31:0] res1, res0;
  int unsigned lat1, lat0, st1, st0, v1, v0;
  logic [40:0] st1_h, st0_h, busy1_h, busy0_h;

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int unsigned flush_at);
    @(posedge clk); #1;
    op_valid_i = 1'b1; alu_control_i = 4'd8; operand_a_i = a; operand_b_i = b; flush_i = 1'b0;
    @(negedge clk);
    st1_h = '0; st0_h = '0; busy1_h = '0; busy0_h = '0;
    st1_h[0] = stall_e1; st0_h[0] = stall_e0;
    st1 = stall_e1 ? 1 : 0; st0 = stall_e0 ? 1 : 0;
    lat1 = 0; lat0 = 0; v1 = 0; v0 = 0; res1 = '0; res0 = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      op_valid_i = 1'b0;
      flush_i = (n == flush_at);
      @(negedge clk);
      st1_h[n] = stall_e1; st0_h[n] = stall_e0;
      busy1_h[n] = busy_e1; busy0_h[n] = busy_e0;
      if (stall_e1) st1++;
      if (stall_e0) st0++;
      if (valid_e1) begin v1++; if (lat1 == 0) begin lat1 = n; res1 = result_e1; end end
      if (valid_e0) begin v0++; if (lat0 == 0) begin lat0 = n; res0 = result_e0; end end
    end
    flush_i = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    run_mul(v.a, v.b, 0);
    check({tag, " accept_stall"}, {31'd0, st1_h[0] & st0_h[0]}, 32'd1);
    check({tag, " result_e1"}, res1, v.prod);
    check({tag, " result_e0"}, res0, v.prod);
    check({tag, " lat_e1"}, lat1, v.lat1);
    check({tag, " lat_e0"}, lat0, v.lat0);
    check({tag, " stall_cycles_e1"}, st1, v.lat1);
    check({tag, " stall_cycles_e0"}, st0, v.lat0);
    check({tag, " valid_pulses"}, {v1[15:0], v0[15:0]}, {16'd1, 16'd1});
  endtask

  vec_t tbl[7];
  vec_t rv;
  int unsigned d1;
  bit seen;

  initial begin
    tbl[0] = '{32'd7,          32'd6,          32'd42,         4,  33};
    tbl[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   33, 33};
    tbl[2] = '{32'd1234,       32'd0,          32'd0,          2,  33};
    tbl[3] = '{32'd3,          32'd5,          32'd15,         4,  33};
    tbl[4] = '{32'h00010000,   32'h00010000,   32'd0,          18, 33};
    tbl[5] = '{32'hDEADBEEF,   32'd1,          32'hDEADBEEF,   2,  33};
    tbl[6] = '{32'd5,          32'h80000000,   32'h80000000,   33, 33};

    arst = 1'b1; op_valid_i = 1'b0; alu_control_i = 4'd0;
    operand_a_i = '0; operand_b_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs_e1", {stall_e1, busy_e1, valid_e1, 29'd0} | result_e1, 32'd0);
    check("reset_outputs_e0", {stall_e0, busy_e0, valid_e0, 29'd0} | result_e0, 32'd0);
    arst = 1'b0;

    foreach (tbl[i]) run_and_check($sformatf("vec%0d", i), tbl[i]);

    // Non-MUL codes never stall or leave IDLE.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      op_valid_i = 1'b1; operand_a_i = $urandom; operand_b_i = $urandom;
      alu_control_i = (i < 10) ? 4'd2 : 4'($urandom_range(0, 15));
      if (alu_control_i == 4'd8) alu_control_i = 4'd9;
      @(negedge clk);
      check($sformatf("nonmul_idle%0d", i), {28'd0, stall_e1, busy_e1, stall_e0, busy_e0}, 32'd0);
    end

    // Flush in IDLE blocks the start.
    @(posedge clk); #1;
    alu_control_i = 4'd8; flush_i = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", {30'd0, stall_e1, stall_e0}, 32'd0);
    @(posedge clk); #1;
    op_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", {30'd0, busy_e1, busy_e0}, 32'd0);

    // Flush mid-run: stall drops on the flush cycle, IDLE the next, no result.
    run_mul(32'd3, 32'h80000000, 5);
    check("flush_stall_cycles_e1", st1, 32'd5);
    check("flush_stall_drop", {30'd0, st1_h[5], st0_h[5]}, 32'd0);
    check("flush_busy_before", {30'd0, busy1_h[4], busy0_h[4]}, 32'd3);
    check("flush_busy_after", {30'd0, busy1_h[6], busy0_h[6]}, 32'd0);
    check("flush_no_valid", {v1[15:0], v0[15:0]}, 32'd0);
    run_and_check("after_flush", tbl[3]);

    // Back-to-back: op held valid through DONE must not relaunch; the next
    // MUL starts in the single IDLE cycle after DONE.
    @(posedge clk); #1;
    op_valid_i = 1'b1; alu_control_i = 4'd8; operand_a_i = 32'd2; operand_b_i = 32'd3;
    seen = 1'b0; d1 = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (valid_e1) begin
        seen = 1'b1; d1 = n;
        check("b2b_first_result", result_e1, 32'd6);
        check("b2b_done_stall", {31'd0, stall_e1}, 32'd0);
      end
    end
    check("b2b_first_lat", d1, 32'd3);
    @(posedge clk); #1;
    operand_a_i = 32'd4; operand_b_i = 32'd5;
    @(negedge clk);
    check("b2b_idle_gap", {30'd0, busy_e1, stall_e1}, 32'd1);
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    seen = 1'b0; d1 = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (valid_e1) begin seen = 1'b1; d1 = n; check("b2b_second_result", result_e1, 32'd20); end
      @(posedge clk); #1;
    end
    check("b2b_second_lat", d1, 32'd4);
    repeat (40) @(posedge clk);

    // Asynchronous reset between edges while in RUN.
    @(posedge clk); #1;
    op_valid_i = 1'b1; alu_control_i = 4'd8; operand_a_i = 32'h123; operand_b_i = 32'hFFFF;
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #3 arst = 1'b1;
    #1;
    check("arst_e1", {stall_e1, busy_e1, valid_e1, 29'd0} | result_e1, 32'd0);
    check("arst_e0", {stall_e0, busy_e0, valid_e0, 29'd0} | result_e0, 32'd0);
    @(negedge clk);
    arst = 1'b0;
    rv = '{32'd9, 32'd9, 32'd81, 5, 33};
    run_and_check("after_arst", rv);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      rv.a    = $urandom;
      rv.b    = $urandom >> $urandom_range(0, 31);
      rv.prod = rv.a * rv.b;
      rv.lat1 = model_lat1(rv.b);
      rv.lat0 = 33;
      run_and_check($sformatf("rand%0d", i), rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
